id_ex_stage: RTL and testbench

- ID/EX pipeline register with load-use hazard detection, bubble insertion, hold on downstream stall, flush on a resolved branch or jump, and same-cycle writeback bypass into the captured operands.
- Sits between decode and execute.
- Its id_ex_rs1, id_ex_rs2, id_ex_rd and control outputs feed the EX-stage forwarding unit and ALU.
- Also drives the IF/ID freeze.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/load_use_detector.sv | 19 +
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, ALU NOP encoding and the control bundle used by ID/EX, forwarding and EX/MEM
package pipeline_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam int ALU_OP_W = 4;
    localparam int REG_IDX_W = 5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = '0;
    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
    } ctrl_t;
    localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a decode-slot read of a register still being loaded by the instruction in ID/EX
// ports: id_* = decode-slot validity, source indices and read enables;
//        ex_* = ID/EX validity, mem_read and destination; load_use = stall-worthy hazard
module load_use_detector
    import pipeline_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbling, stall hold, flush and WB bypass
// ports: clk/rst_n; id_* = decoded instruction; wb_* = writeback port for bypass;
//        ex_stall/ex_flush = downstream control; stall_if_id = IF/ID freeze;
//        id_ex_* = registered slot; stall_cycles = saturating load-use bubble count
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic                 id_alu_src,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_reg_write,
    input  logic                 id_mem_to_reg,
    input  logic                 id_branch,
    input  logic                 id_jump,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_stall,
    input  logic                 ex_flush,
    output logic                 stall_if_id,
    output logic                 id_ex_valid,
    output logic [XLEN-1:0]      id_ex_pc,
    output logic [XLEN-1:0]      id_ex_imm,
    output logic [XLEN-1:0]      id_ex_rs1_data,
    output logic [XLEN-1:0]      id_ex_rs2_data,
    output logic [REG_IDX_W-1:0] id_ex_rs1,
    output logic [REG_IDX_W-1:0] id_ex_rs2,
    output logic [REG_IDX_W-1:0] id_ex_rd,
    output logic [ALU_OP_W-1:0]  id_ex_alu_op,
    output logic                 id_ex_alu_src,
    output logic                 id_ex_mem_read,
    output logic                 id_ex_mem_write,
    output logic                 id_ex_reg_write,
    output logic                 id_ex_mem_to_reg,
    output logic                 id_ex_branch,
    output logic                 id_ex_jump,
    output logic [PERF_W-1:0]    stall_cycles
);
    // an all-zero slot is exactly a bubble (ALU_OP_NOP and BUBBLE_CTRL are zero)
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [ALU_OP_W-1:0]  alu_op;
        ctrl_t                ctrl;
    } slot_t;

    slot_t slot_q, slot_d;
    logic  load_use, bubble;

    load_use_detector u_load_use_detector (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (slot_q.valid),
        .ex_mem_read (slot_q.ctrl.mem_read),
        .ex_rd       (slot_q.rd),
        .load_use    (load_use)
    );

    // gated by rst_n so the freeze reads 0 while reset is held, whatever ex_stall does
    assign stall_if_id = rst_n & (ex_stall | (load_use & ~ex_flush));
    // flush beats hold; an empty decode slot is captured as a bubble too
    assign bubble = ex_flush | (~ex_stall & (load_use | ~id_valid));

    always_comb begin
        slot_d          = '0;
        slot_d.valid    = 1'b1;
        slot_d.pc       = id_pc;
        slot_d.imm      = id_imm;
        slot_d.rs1      = id_rs1;
        slot_d.rs2      = id_rs2;
        slot_d.rd       = id_rd;
        slot_d.alu_op   = id_alu_op;
        slot_d.ctrl     = '{alu_src: id_alu_src, mem_read: id_mem_read, mem_write: id_mem_write,
                            reg_write: id_reg_write, mem_to_reg: id_mem_to_reg,
                            branch: id_branch, jump: id_jump};
        slot_d.rs1_data = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
        slot_d.rs2_data = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (bubble) begin
            slot_q <= '0;
        end else if (!ex_stall) begin
            slot_q <= slot_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (load_use && !ex_flush && !ex_stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign id_ex_valid      = slot_q.valid;
    assign id_ex_pc         = slot_q.pc;
    assign id_ex_imm        = slot_q.imm;
    assign id_ex_rs1_data   = slot_q.rs1_data;
    assign id_ex_rs2_data   = slot_q.rs2_data;
    assign id_ex_rs1        = slot_q.rs1;
    assign id_ex_rs2        = slot_q.rs2;
    assign id_ex_rd         = slot_q.rd;
    assign id_ex_alu_op     = slot_q.alu_op;
    assign id_ex_alu_src    = slot_q.ctrl.alu_src;
    assign id_ex_mem_read   = slot_q.ctrl.mem_read;
    assign id_ex_mem_write  = slot_q.ctrl.mem_write;
    assign id_ex_reg_write  = slot_q.ctrl.reg_write;
    assign id_ex_mem_to_reg = slot_q.ctrl.mem_to_reg;
    assign id_ex_branch     = slot_q.ctrl.branch;
    assign id_ex_jump       = slot_q.ctrl.jump;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (counter built 4 bits wide)
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch, id_jump;
    logic        wb_reg_write, ex_stall, ex_flush;
    logic        stall_if_id, id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic        id_ex_mem_to_reg, id_ex_branch, id_ex_jump;
    logic [3:0]  stall_cycles;

    int errors = 0;
    int checks = 0;
    int exp_sc;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .PERF_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .id_jump(id_jump),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .stall_if_id(stall_if_id),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_imm(id_ex_imm),
        .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one valid instruction; ld=1 makes it a load (mem_read, mem_to_reg)
    task automatic put(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic ld);
        id_valid = 1'b1; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = 32'h10; id_alu_op = 4'h3; id_alu_src = 1'b0;
        id_mem_read = ld; id_mem_to_reg = ld; id_mem_write = 1'b0;
        id_reg_write = 1'b1; id_branch = 1'b0; id_jump = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1; id_pc = 32'hAAAA; id_rs1 = 5; id_rs2 = 6; id_rd = 7;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222;
        id_imm = 32'h3333; id_alu_op = 4'hF; id_alu_src = 1; id_mem_read = 1; id_mem_write = 1;
        id_reg_write = 1; id_mem_to_reg = 1; id_branch = 1; id_jump = 1;
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'h4444; ex_stall = 1; ex_flush = 1;
        repeat (3) tick();
        check("rst_valid", id_ex_valid, 0);
        check("rst_pc", id_ex_pc, 0);
        check("rst_rs1_data", id_ex_rs1_data, 0);
        check("rst_rd", id_ex_rd, 0);
        check("rst_ctrl", {id_ex_alu_op, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
                           id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch, id_ex_jump}, 0);
        check("rst_stall_if_id", stall_if_id, 0);
        check("rst_stall_cycles", stall_cycles, 0);

        ex_stall = 0; ex_flush = 0; wb_reg_write = 0;
        put(32'h100, 1, 2, 3, 1, 1, 32'h11, 32'h22, 0);
        rst_n = 1'b1;
        #1 check("post_rst_not_yet", id_ex_valid, 0);
        tick();
        check("cap_valid", id_ex_valid, 1);
        check("cap_pc", id_ex_pc, 32'h100);
        check("cap_rd", id_ex_rd, 3);
        check("cap_rs1_data", id_ex_rs1_data, 32'h11);
        check("cap_alu_op", id_ex_alu_op, 3);
        check("cap_reg_write", id_ex_reg_write, 1);

        put(32'h104, 1, 2, 5, 1, 1, 0, 0, 1);
        tick();
        check("load_mem_read", id_ex_mem_read, 1);
        put(32'h108, 5, 6, 7, 1, 0, 32'h55, 32'h66, 0);
        #1 check("lu_stall", stall_if_id, 1);
        tick();
        check("lu_bubble_valid", id_ex_valid, 0);
        check("lu_bubble_rd", id_ex_rd, 0);
        check("lu_bubble_mem_read", id_ex_mem_read, 0);
        check("lu_count", stall_cycles, 1);
        check("lu_stall_released", stall_if_id, 0);
        tick();
        check("lu_dep_valid", id_ex_valid, 1);
        check("lu_dep_pc", id_ex_pc, 32'h108);
        check("lu_dep_rs1", id_ex_rs1, 5);

        put(32'h10C, 1, 2, 5, 1, 1, 0, 0, 1);
        tick();
        put(32'h110, 5, 6, 7, 0, 1, 0, 0, 0);
        #1 check("nouse_stall", stall_if_id, 0);
        tick();
        check("nouse_valid", id_ex_valid, 1);
        check("nouse_pc", id_ex_pc, 32'h110);
        check("nouse_count", stall_cycles, 1);

        put(32'h114, 1, 2, 0, 1, 1, 0, 0, 1);
        tick();
        put(32'h118, 0, 0, 7, 1, 1, 0, 0, 0);
        #1 check("x0_stall", stall_if_id, 0);
        tick();
        check("x0_pc", id_ex_pc, 32'h118);

        put(32'h200, 4, 5, 6, 1, 1, 32'hAB, 32'hCD, 0);
        tick();
        check("hold_cap_pc", id_ex_pc, 32'h200);
        ex_stall = 1;
        put(32'h204, 4, 5, 6, 1, 1, 32'h1, 32'h2, 0);
        wb_reg_write = 1; wb_rd = 4; wb_data = 32'hFEED;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", stall_if_id, 1);
            tick();
            check("hold_pc", id_ex_pc, 32'h200);
            check("hold_rs1_data", id_ex_rs1_data, 32'hAB);
        end
        ex_flush = 1;
        tick();
        check("flush_stall_valid", id_ex_valid, 0);
        check("flush_stall_pc", id_ex_pc, 0);
        ex_flush = 0; ex_stall = 0; wb_reg_write = 0;

        put(32'h300, 1, 2, 9, 1, 1, 0, 0, 1);
        tick();
        put(32'h304, 9, 0, 3, 1, 0, 0, 0, 0);
        ex_flush = 1;
        #1 check("flush_lu_stall", stall_if_id, 0);
        tick();
        check("flush_lu_valid", id_ex_valid, 0);
        check("flush_lu_count", stall_cycles, 1);
        ex_flush = 0;

        put(32'h308, 1, 2, 3, 1, 1, 32'h9, 32'h9, 1);
        id_valid = 0;
        tick();
        check("inv_valid", id_ex_valid, 0);
        check("inv_reg_write", id_ex_reg_write, 0);
        check("inv_mem_read", id_ex_mem_read, 0);
        check("inv_pc", id_ex_pc, 0);

        put(32'h400, 3, 7, 8, 1, 1, 32'h33, 32'h0, 0);
        wb_reg_write = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        tick();
        check("byp_rs2", id_ex_rs2_data, 32'hDEADBEEF);
        check("byp_rs1_untouched", id_ex_rs1_data, 32'h33);
        put(32'h404, 0, 0, 8, 1, 1, 32'h0, 32'h0, 0);
        wb_rd = 0;
        tick();
        check("byp_x0_rs2", id_ex_rs2_data, 0);
        check("byp_x0_rs1", id_ex_rs1_data, 0);
        put(32'h408, 7, 2, 8, 1, 1, 32'h77, 32'h0, 0);
        wb_reg_write = 0; wb_rd = 7;
        tick();
        check("byp_disabled", id_ex_rs1_data, 32'h77);

        exp_sc = 1;
        for (int i = 0; i < 17; i++) begin
            put(32'h600, 1, 2, 10, 1, 1, 0, 0, 1);
            tick();
            put(32'h604, 2, 10, 11, 0, 1, 0, 0, 0);
            tick();
            exp_sc = (exp_sc == 15) ? 15 : exp_sc + 1;
            check("sat_count", stall_cycles, exp_sc);
            tick();
        end
        check("sat_final", stall_cycles, 15);

        put(32'h500, 1, 2, 3, 1, 1, 0, 0, 0);
        tick();
        ex_stall = 1;
        #3 rst_n = 1'b0;
        #1 check("mid_rst_valid", id_ex_valid, 0);
        check("mid_rst_pc", id_ex_pc, 0);
        check("mid_rst_count", stall_cycles, 0);
        check("mid_rst_stall", stall_if_id, 0);
        rst_n = 1'b1; ex_stall = 0;
        tick();
        check("resume_pc", id_ex_pc, 32'h500);
        check("resume_valid", id_ex_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
